// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables, D/A squash, drain after reset.
// Enables/flush/bubble are combinational from state and inputs; counters update each clock.
// Memory busy freezes every stage; branch > load-use > fetch miss resolve in that order.
module pipe_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       d_regA,
  input  logic [4:0]       d_regB,
  input  logic             d_useA,
  input  logic             d_useB,
  input  logic [4:0]       a_regD,
  input  logic             a_w_en,
  input  logic             a_is_load,
  input  logic             a_branch_taken,
  input  logic             i_busy,
  input  logic             m_busy,
  input  logic             clr_cnt,
  output logic             f_en,
  output logic             d_en,
  output logic             a_en,
  output logic             m_en,
  output logic             wb_en,
  output logic             d_flush,
  output logic             a_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [IW-1:0]    INIT_ONE  = IW'(1);
  localparam logic [WW-1:0]    WAIT_MAX  = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0]    WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  localparam logic [WW-1:0]    WAIT_ONE  = WW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] init_cnt;
  logic [WW-1:0] wait_cnt;
  logic          load_use;

  // Load result in A not yet available to the instruction sitting in D.
  always_comb begin
    load_use = a_is_load & a_w_en & (a_regD != 5'd0) &
               ((d_useA & (d_regA == a_regD)) | (d_useB & (d_regB == a_regD)));
  end

  // Next state and stage controls; squash-everything is the safe default.
  always_comb begin
    state_nxt = state;
    f_en      = 1'b0;
    d_en      = 1'b0;
    a_en      = 1'b0;
    m_en      = 1'b0;
    wb_en     = 1'b0;
    d_flush   = 1'b1;
    a_bubble  = 1'b1;
    case (state)
      S_INIT: begin
        if (init_cnt == INIT_LAST) state_nxt = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        if (m_busy) begin
          // Whole pipe holds its contents while memory is outstanding.
          d_flush   = 1'b0;
          a_bubble  = 1'b0;
          state_nxt = S_MEM_WAIT;
        end else begin
          state_nxt = S_RUN;
          if (a_branch_taken) begin
            // Redirect: both younger instructions are on the wrong path.
            f_en  = 1'b1; d_en = 1'b1; a_en = 1'b1; m_en = 1'b1; wb_en = 1'b1;
          end else if (load_use) begin
            // Hold F and D, insert one bubble into A.
            a_en     = 1'b1; m_en = 1'b1; wb_en = 1'b1;
            d_flush  = 1'b0;
          end else if (i_busy) begin
            // No valid fetch: feed a NOP into D, let the rest drain forward.
            d_en     = 1'b1; a_en = 1'b1; m_en = 1'b1; wb_en = 1'b1;
            a_bubble = 1'b0;
          end else begin
            f_en     = 1'b1; d_en = 1'b1; a_en = 1'b1; m_en = 1'b1; wb_en = 1'b1;
            d_flush  = 1'b0;
            a_bubble = 1'b0;
          end
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Drain counter; parks on its last value once RUN is reached.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                      init_cnt <= '0;
    else if (state == S_INIT && init_cnt != INIT_LAST) init_cnt <= init_cnt + INIT_ONE;
  end

  // Consecutive busy cycles; the first busy cycle is seen in RUN, so entry loads 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else begin
      case (state)
        S_RUN:      wait_cnt <= m_busy ? WAIT_ONE : '0;
        S_MEM_WAIT: begin
          if (!m_busy)                   wait_cnt <= '0;
          else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_ONE;
        end
        default:    wait_cnt <= '0;
      endcase
    end
  end

  // Sticky timeout flag; raised on the MEM_TIMEOUT-th busy cycle, only clr_cnt drops it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      mem_timeout <= 1'b0;
    else if (clr_cnt)
      mem_timeout <= 1'b0;
    else if (state == S_MEM_WAIT && m_busy && wait_cnt == WAIT_LAST)
      mem_timeout <= 1'b1;
  end

  // Saturating count of cycles without a fetch advance, excluding the drain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (clr_cnt)
      stall_cnt <= '0;
    else if (state != S_INIT && !f_en && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected outputs queued at drive time, popped at sample time.
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  d_regA, d_regB, a_regD;
  logic        d_useA, d_useB, a_w_en, a_is_load, a_branch_taken, i_busy, m_busy, clr_cnt;
  logic        f_en, d_en, a_en, m_en, wb_en, d_flush, a_bubble, mem_timeout;
  logic [15:0] stall_cnt;

  pipe_ctrl #(.INIT_CYCLES(4), .MEM_TIMEOUT(64), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .d_regA(d_regA), .d_regB(d_regB), .d_useA(d_useA), .d_useB(d_useB),
    .a_regD(a_regD), .a_w_en(a_w_en), .a_is_load(a_is_load),
    .a_branch_taken(a_branch_taken), .i_busy(i_busy), .m_busy(m_busy), .clr_cnt(clr_cnt),
    .f_en(f_en), .d_en(d_en), .a_en(a_en), .m_en(m_en), .wb_en(wb_en),
    .d_flush(d_flush), .a_bubble(a_bubble), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  en;
    logic        dfl;
    logic        abub;
    logic        to;
    logic [15:0] cnt;
  } exp_t;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] LU   = 5'b00111;
  localparam logic [4:0] IB   = 5'b01111;

  exp_t        exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_to  = 1'b0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
  endtask

  // Queue the expectation for the current cycle, let inputs settle, then pop and compare.
  task automatic check_now(input string tag, input logic [4:0] en, input logic dfl, input logic abub);
    exp_t e;
    exp_q.push_back('{en: en, dfl: dfl, abub: abub, to: exp_to, cnt: exp_cnt});
    #2;
    e = exp_q.pop_front();
    cmp({tag, ".en"},   {27'd0, f_en, d_en, a_en, m_en, wb_en}, {27'd0, e.en});
    cmp({tag, ".dfl"},  {31'd0, d_flush},     {31'd0, e.dfl});
    cmp({tag, ".abub"}, {31'd0, a_bubble},    {31'd0, e.abub});
    cmp({tag, ".to"},   {31'd0, mem_timeout}, {31'd0, e.to});
    cmp({tag, ".cnt"},  {16'd0, stall_cnt},   {16'd0, e.cnt});
  endtask

  // One clock cycle: check, advance the expected counters, move to the next drive point.
  task automatic step(input string tag, input logic [4:0] en, input logic dfl,
                      input logic abub, input logic in_init);
    check_now(tag, en, dfl, abub);
    if (clr_cnt) begin
      exp_cnt = '0;
      exp_to  = 1'b0;
    end else if (!in_init && !en[4] && exp_cnt != 16'hFFFF) begin
      exp_cnt = exp_cnt + 16'd1;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    d_regA = '0; d_regB = '0; a_regD = '0;
    d_useA = 0; d_useB = 0; a_w_en = 0; a_is_load = 0;
    a_branch_taken = 0; i_busy = 0; m_busy = 0; clr_cnt = 0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    a_is_load = 1; a_w_en = 1; a_regD = rd;
  endtask

  task automatic do_init(input string tag);
    for (int i = 0; i < 4; i++) step(tag, NONE, 1, 1, 1);
    step({tag, ".first_run"}, ALL, 0, 0, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle();
    #3;
    check_now("rst_hold0", NONE, 1, 1);
    @(negedge clock);
    m_busy = 1; a_branch_taken = 1;          // inputs ignored while reset is held
    check_now("rst_hold1", NONE, 1, 1);
    idle();
    @(negedge clock);
    reset = 1'b1;
    m_busy = 1; i_busy = 1;                   // inputs ignored during drain
    for (int i = 0; i < 4; i++) step("init", NONE, 1, 1, 1);
    idle();
    step("run0", ALL, 0, 0, 0);

    // Load-use hazard through rs2, and the rd==x0 exemption.
    set_load(5'd5); d_useB = 1; d_regB = 5'd5;
    step("lu_rs2", LU, 0, 1, 0);
    idle();
    step("lu_clear", ALL, 0, 0, 0);
    set_load(5'd0); d_useB = 1; d_regB = 5'd0;
    step("lu_x0", ALL, 0, 0, 0);
    idle(); set_load(5'd7); d_useA = 1; d_regA = 5'd7;
    step("lu_rs1", LU, 0, 1, 0);
    idle(); set_load(5'd5); d_useB = 0; d_regB = 5'd5;
    step("lu_nouse", ALL, 0, 0, 0);
    idle(); set_load(5'd5); a_w_en = 0; d_useB = 1; d_regB = 5'd5;
    step("lu_nowr", ALL, 0, 0, 0);

    // Branch outranks load-use and fetch miss; load-use outranks fetch miss.
    idle(); set_load(5'd5); d_useB = 1; d_regB = 5'd5; i_busy = 1; a_branch_taken = 1;
    step("br_prio", ALL, 1, 1, 0);
    a_branch_taken = 0;
    step("lu_over_ib", LU, 0, 1, 0);
    idle(); i_busy = 1;
    step("ibusy", IB, 1, 0, 0);
    idle();
    step("after_ib", ALL, 0, 0, 0);

    // Three-cycle memory wait, memory outranking a taken branch, same-cycle resume.
    m_busy = 1; a_branch_taken = 1;
    for (int k = 0; k < 3; k++) step("mwait", NONE, 0, 0, 0);
    idle();
    step("mresume", ALL, 0, 0, 0);
    step("mafter", ALL, 0, 0, 0);
    m_busy = 1;
    step("mwait1", NONE, 0, 0, 0);
    m_busy = 0; set_load(5'd9); d_useA = 1; d_regA = 5'd9;
    step("mresume_lu", LU, 0, 1, 0);
    idle();
    step("mresume_lu2", ALL, 0, 0, 0);

    // Clear landing on the setting cycle wins over the set.
    m_busy = 1;
    for (int k = 1; k <= 66; k++) begin
      clr_cnt = (k == 64);
      step("clr_prio", NONE, 0, 0, 0);
    end
    idle();
    step("clr_prio_end", ALL, 0, 0, 0);

    // Timeout rises after the 64th busy cycle and stays set after resume.
    m_busy = 1;
    for (int k = 1; k <= 70; k++) begin
      if (k == 65) exp_to = 1'b1;
      step("tmo", NONE, 0, 0, 0);
    end
    m_busy = 0;
    step("tmo_resume", ALL, 0, 0, 0);
    step("tmo_sticky", ALL, 0, 0, 0);
    clr_cnt = 1;
    step("tmo_clr", ALL, 0, 0, 0);
    clr_cnt = 0;
    step("tmo_cleared", ALL, 0, 0, 0);

    // Asynchronous reset in the middle of a wait with flag and counter nonzero.
    m_busy = 1;
    for (int k = 1; k <= 66; k++) begin
      if (k == 65) exp_to = 1'b1;
      step("tmo2", NONE, 0, 0, 0);
    end
    #1;
    reset  = 1'b0;
    exp_to = 1'b0;
    exp_cnt = '0;
    check_now("arst", NONE, 1, 1);
    @(negedge clock);
    check_now("arst_hold", NONE, 1, 1);
    idle();
    @(negedge clock);
    reset = 1'b1;
    do_init("reinit");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
